// File: rtl/ddr2dbuf_gen_if.sv
// ddr2dbuf_gen_if -- bundle of the job-control, DDR beat stream and
// data-buffer write signals of ddr2dbuf_gen.
//   job control : start, mode, ch_num/row_num/pix_num, fc_len, base_addr,
//                 abort in; busy, done out
//   beat stream : ddr_data, ddr_valid in; ddr_ready out
//   dbuf write  : dbuf_wr_addr, dbuf_wr_data (one lane per bank),
//                 dbuf_wr_en (one-hot or zero) out
// slave = the generator, master = whoever drives jobs and beats.
interface ddr2dbuf_gen_if #(
    parameter int DATA_W = 16,
    parameter int BATCH  = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
);
    localparam int BEAT_W = DATA_W * BATCH;

    logic                   start;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       ch_num;
    logic [CNT_W-1:0]       row_num;
    logic [CNT_W-1:0]       pix_num;
    logic [ADDR_W-1:0]      fc_len;
    logic [ADDR_W-1:0]      base_addr;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic [BEAT_W-1:0]      ddr_data;
    logic                   ddr_valid;
    logic                   ddr_ready;
    logic [ADDR_W-1:0]      dbuf_wr_addr;
    logic [3:0][BEAT_W-1:0] dbuf_wr_data;
    logic [3:0]             dbuf_wr_en;

    modport slave (
        input  start, mode, ch_num, row_num, pix_num, fc_len, base_addr, abort,
        input  ddr_data, ddr_valid,
        output busy, done, ddr_ready, dbuf_wr_addr, dbuf_wr_data, dbuf_wr_en
    );

    modport master (
        output start, mode, ch_num, row_num, pix_num, fc_len, base_addr, abort,
        output ddr_data, ddr_valid,
        input  busy, done, ddr_ready, dbuf_wr_addr, dbuf_wr_data, dbuf_wr_en
    );
endinterface

// File: rtl/ddr2dbuf_gen.sv
// ddr2dbuf_gen -- scatters a stream of DDR beats into four data-buffer
// banks laid out as a 2x2 row/pixel tile.
//   clk  : sole clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ddr2dbuf_gen_if.slave (job control, beat stream, bank writes)
// Conv jobs walk channel (innermost), pixel, row; the row/pixel LSBs pick the
// bank and the remaining bits plus the channel form the in-bank offset.
// FC jobs deal beats round-robin over the banks, advancing the address once
// per full round. Every accepted beat becomes one registered bank write.

// One bank's write-data lane: loads a beat when its bank is written, holds
// the previous beat otherwise.
module ddr2dbuf_lane #(
    parameter int BEAT_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [BEAT_W-1:0] data_o
);
    logic [BEAT_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      data_q <= '0;
        else if (we_i) data_q <= data_i;
    end

    assign data_o = data_q;
endmodule

module ddr2dbuf_gen #(
    parameter int DATA_W    = 16,
    parameter int BATCH     = 8,
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = $clog2(BUF_DEPTH),
    parameter int CNT_W     = 4
) (
    input logic           clk,
    input logic           rst,
    ddr2dbuf_gen_if.slave bus
);
    localparam int BANK_NUM = 4;
    localparam int BEAT_W   = DATA_W * BATCH;
    localparam int OFF_W    = 3 * CNT_W - 2;

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;

    state_e              state_q, state_d;
    logic                fc_q;
    logic [CNT_W-1:0]    ch_num_q, row_num_q, pix_num_q;
    logic [ADDR_W-1:0]   fc_len_q, base_q;
    logic [CNT_W-1:0]    ch_cnt_q, row_cnt_q, pix_cnt_q;
    logic [1:0]          fc_bank_q;
    logic [ADDR_W-1:0]   fc_word_q;
    logic [BANK_NUM-1:0] wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                accept, last_beat;
    logic [1:0]          bank;
    logic [ADDR_W-1:0]   addr;
    logic [OFF_W-1:0]    conv_off;
    logic [BANK_NUM-1:0] lane_we;
    logic [BANK_NUM-1:0][BEAT_W-1:0] lane_data;

    assign accept   = (state_q == RUN) && bus.ddr_valid;
    assign conv_off = {ch_cnt_q, row_cnt_q[CNT_W-1:1], pix_cnt_q[CNT_W-1:1]};

    always_comb begin
        bank      = {row_cnt_q[0], pix_cnt_q[0]};
        addr      = base_q + ADDR_W'(conv_off);
        last_beat = (ch_cnt_q == ch_num_q) && (pix_cnt_q == pix_num_q) &&
                    (row_cnt_q == row_num_q);
        if (fc_q) begin
            bank      = fc_bank_q;
            addr      = base_q + fc_word_q;
            last_beat = (fc_bank_q == 2'd3) && (fc_word_q == fc_len_q);
        end
        lane_we = accept ? (BANK_NUM'(1) << bank) : '0;
    end

    // Reserved modes skip RUN entirely so they only produce the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = bus.mode[1] ? LAST : RUN;
            RUN: begin
                if (bus.abort)                 state_d = IDLE;
                else if (accept && last_beat)  state_d = LAST;
            end
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q      <= 1'b0;
            ch_num_q  <= '0;
            row_num_q <= '0;
            pix_num_q <= '0;
            fc_len_q  <= '0;
            base_q    <= '0;
            ch_cnt_q  <= '0;
            row_cnt_q <= '0;
            pix_cnt_q <= '0;
            fc_bank_q <= '0;
            fc_word_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            fc_q      <= bus.mode[0];
            ch_num_q  <= bus.ch_num;
            row_num_q <= bus.row_num;
            pix_num_q <= bus.pix_num;
            fc_len_q  <= bus.fc_len;
            base_q    <= bus.base_addr;
            ch_cnt_q  <= '0;
            row_cnt_q <= '0;
            pix_cnt_q <= '0;
            fc_bank_q <= '0;
            fc_word_q <= '0;
        end else if (accept) begin
            if (fc_q) begin
                fc_bank_q <= fc_bank_q + 2'd1;
                if (fc_bank_q == 2'd3) fc_word_q <= fc_word_q + ADDR_W'(1);
            end else if (ch_cnt_q == ch_num_q) begin
                ch_cnt_q <= '0;
                if (pix_cnt_q == pix_num_q) begin
                    pix_cnt_q <= '0;
                    row_cnt_q <= row_cnt_q + CNT_W'(1);
                end else begin
                    pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                end
            end else begin
                ch_cnt_q <= ch_cnt_q + CNT_W'(1);
            end
        end
    end

    // Address only moves on a write so idle cycles show the last one issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q <= lane_we;
            if (accept) wr_addr_q <= addr;
        end
    end

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_lane
        ddr2dbuf_lane #(.BEAT_W(BEAT_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we_i   (lane_we[g]),
            .data_i (bus.ddr_data),
            .data_o (lane_data[g])
        );
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == LAST);
    assign bus.ddr_ready    = (state_q == RUN);
    assign bus.dbuf_wr_en   = wr_en_q;
    assign bus.dbuf_wr_addr = wr_addr_q;
    assign bus.dbuf_wr_data = lane_data;
endmodule

// File: tb/tb_ddr2dbuf_gen.sv
// tb_ddr2dbuf_gen -- self-checking bench for ddr2dbuf_gen. Expected write
// streams come from nested loops over the job geometry; observed writes are
// collected by a negedge monitor and compared after each job.
module tb_ddr2dbuf_gen;
    localparam int DW = 16, BT = 2, AW = 8, CW = 3, BW = DW * BT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ddr2dbuf_gen_if #(.DATA_W(DW), .BATCH(BT), .ADDR_W(AW), .CNT_W(CW)) bus();

    ddr2dbuf_gen #(.DATA_W(DW), .BATCH(BT), .BUF_DEPTH(256), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]         en;
        logic [AW-1:0]      addr;
        logic [3:0][BW-1:0] data;
        logic               done;
    } wr_t;

    typedef struct {
        logic [1:0] mode;
        int ch, row, pix, fcl, base, gap;
        int exp_n;
    } job_t;

    wr_t                obs[$];
    int                 n_tests = 0, n_fail = 0;
    int                 done_cnt = 0, busy_cnt = 0, rdy_last = 0;
    logic [3:0][BW-1:0] shadow = '0;
    int                 exp_bank[$], exp_addr[$];
    logic [BW-1:0]      beats[$];

    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (bus.ddr_ready) rdy_last++;
            end
            if (bus.dbuf_wr_en != 4'b0) begin
                w.en = bus.dbuf_wr_en; w.addr = bus.dbuf_wr_addr;
                w.data = bus.dbuf_wr_data; w.done = bus.done;
                obs.push_back(w);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference write stream straight from the job geometry.
    task automatic build_model(input job_t j);
        exp_bank.delete(); exp_addr.delete(); beats.delete();
        if (j.mode == 2'b00) begin
            for (int r = 0; r <= j.row; r++)
                for (int p = 0; p <= j.pix; p++)
                    for (int c = 0; c <= j.ch; c++) begin
                        exp_bank.push_back((r % 2) * 2 + (p % 2));
                        exp_addr.push_back((j.base + c * (1 << (2 * (CW - 1))) +
                                            (r / 2) * (1 << (CW - 1)) + p / 2) % (1 << AW));
                    end
        end else if (j.mode == 2'b01) begin
            for (int k = 0; k <= 4 * j.fcl + 3; k++) begin
                exp_bank.push_back(k % 4);
                exp_addr.push_back((j.base + k / 4) % (1 << AW));
            end
        end
        for (int i = 0; i < exp_bank.size(); i++) beats.push_back(BW'($urandom));
    endtask

    task automatic drive_cfg(input job_t j);
        bus.mode = j.mode; bus.ch_num = CW'(j.ch); bus.row_num = CW'(j.row);
        bus.pix_num = CW'(j.pix); bus.fc_len = AW'(j.fcl); bus.base_addr = AW'(j.base);
    endtask

    task automatic check_write(input string nm, input int i);
        shadow[exp_bank[i]] = beats[i];
        chk({nm, "_en"},   obs[i].en,   4'b1 << exp_bank[i]);
        chk({nm, "_addr"}, obs[i].addr, exp_addr[i]);
        chk({nm, "_data"}, obs[i].data, shadow);
    endtask

    task automatic run_job(input job_t j);
        int idx, cyc, n;
        bit seen;
        build_model(j);
        n = exp_bank.size();
        obs.delete(); done_cnt = 0; busy_cnt = 0; rdy_last = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; drive_cfg(j);
        idx = 0; cyc = 0; seen = 0;
        while (!seen && cyc < 3000) begin
            @(posedge clk); #1;
            // config noise and stray starts must be ignored once the job runs
            bus.start = ($urandom_range(3) == 0);
            bus.mode = 2'($urandom); bus.ch_num = CW'($urandom); bus.row_num = CW'($urandom);
            bus.pix_num = CW'($urandom); bus.fc_len = AW'($urandom); bus.base_addr = AW'($urandom);
            bus.abort = !bus.ddr_ready && ($urandom_range(1) == 1);
            bus.ddr_valid = (idx < n) && ($urandom_range(99) >= j.gap);
            bus.ddr_data = bus.ddr_valid ? beats[idx] : BW'($urandom);
            @(negedge clk);
            if (bus.done) seen = 1;
            if (bus.ddr_valid && bus.ddr_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.ddr_valid = 1'b1; bus.abort = 1'b1;
        repeat (3) begin bus.ddr_data = BW'($urandom); @(posedge clk); #1; end
        bus.ddr_valid = 1'b0; bus.abort = 1'b0;
        chk("done_seen", seen, 1);
        chk("n_writes", obs.size(), n);
        chk("done_cnt", done_cnt, 1);
        chk("ready_in_last", rdy_last, 0);
        if (j.gap == 0) chk("busy_cycles", busy_cnt, n + 1);
        for (int i = 0; i < n && i < obs.size(); i++) begin
            check_write("wr", i);
            chk("wr_done", obs[i].done, (i == n - 1));
        end
    endtask

    job_t tbl[8];
    job_t jx;
    int   a29[8] = '{'h10, 'h20, 'h10, 'h20, 'h10, 'h20, 'h10, 'h20};
    int   e29[8] = '{1, 1, 2, 2, 4, 4, 8, 8};

    initial begin
        bus.start = 0; bus.mode = 0; bus.ch_num = 0; bus.row_num = 0; bus.pix_num = 0;
        bus.fc_len = 0; bus.base_addr = 0; bus.abort = 0; bus.ddr_data = 0; bus.ddr_valid = 0;

        tbl[0] = '{2'b00, 1, 1, 1, 0, 'h10, 0, 8};
        tbl[1] = '{2'b01, 0, 0, 0, 1, 'hFF, 0, 8};
        tbl[2] = '{2'b00, 1, 1, 1, 0, 'h10, 40, 8};
        tbl[3] = '{2'b00, 2, 3, 1, 0, 'hF0, 30, 24};
        tbl[4] = '{2'b01, 0, 0, 0, 2, 'h7E, 50, 12};
        tbl[5] = '{2'b11, 0, 0, 0, 0, 'h00, 0, 0};
        tbl[6] = '{2'b00, 0, 0, 0, 0, 'h05, 0, 1};
        tbl[7] = '{2'b00, 7, 7, 7, 0, 'h33, 20, 512};

        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.ddr_ready, 0);
        chk("rst_en", bus.dbuf_wr_en, 0);
        chk("rst_addr", bus.dbuf_wr_addr, 0);
        chk("rst_data", bus.dbuf_wr_data, 0);
        @(posedge clk); #1; rst = 1'b1;

        for (int t = 0; t < 8; t++) begin
            run_job(tbl[t]);
            chk("tbl_n_writes", obs.size(), tbl[t].exp_n);
            if (t == 0)
                for (int i = 0; i < 8 && i < obs.size(); i++) begin
                    chk("conv29_addr", obs[i].addr, a29[i]);
                    chk("conv29_en", obs[i].en, e29[i]);
                end
            if (t == 1)
                for (int i = 0; i < 8 && i < obs.size(); i++) begin
                    chk("fc30_addr", obs[i].addr, (i < 4) ? 'hFF : 'h00);
                    chk("fc30_en", obs[i].en, 4'b1 << (i % 4));
                end
        end

        // abort in the cycle the third beat is accepted
        jx = '{2'b00, 3, 3, 3, 0, 'h40, 0, 64};
        build_model(jx);
        obs.delete(); done_cnt = 0;
        @(posedge clk); #1; bus.start = 1'b1; drive_cfg(jx);
        @(posedge clk); #1; bus.start = 1'b0; bus.ddr_valid = 1'b1; bus.ddr_data = beats[0];
        @(posedge clk); #1; bus.ddr_data = beats[1];
        @(posedge clk); #1; bus.ddr_data = beats[2]; bus.abort = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0; bus.ddr_valid = 1'b0;
        chk("abort_idle", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", obs.size(), 3);
        chk("abort_done", done_cnt, 0);
        for (int i = 0; i < 3 && i < obs.size(); i++) check_write("abort", i);

        for (int r = 0; r < 4; r++) begin
            jx.mode = 2'($urandom_range(1));
            jx.ch = $urandom_range(3); jx.row = $urandom_range(3); jx.pix = $urandom_range(3);
            jx.fcl = $urandom_range(5); jx.base = $urandom_range(255); jx.gap = $urandom_range(60);
            run_job(jx);
        end

        // reset pulse in the middle of a job
        jx = '{2'b00, 3, 3, 3, 0, 'h00, 0, 64};
        @(posedge clk); #1; bus.start = 1'b1; drive_cfg(jx);
        @(posedge clk); #1; bus.start = 1'b0; bus.ddr_valid = 1'b1;
        repeat (5) begin bus.ddr_data = BW'($urandom); @(posedge clk); #1; end
        rst = 1'b0; #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ready", bus.ddr_ready, 0);
        chk("midrst_en", bus.dbuf_wr_en, 0);
        chk("midrst_addr", bus.dbuf_wr_addr, 0);
        chk("midrst_data", bus.dbuf_wr_data, 0);
        obs.delete(); done_cnt = 0; shadow = '0;
        @(posedge clk); #1; rst = 1'b1;
        repeat (6) begin bus.ddr_data = BW'($urandom); @(posedge clk); #1; end
        bus.ddr_valid = 1'b0;
        chk("postrst_writes", obs.size(), 0);
        chk("postrst_done", done_cnt, 0);

        jx = '{2'b10, 0, 0, 0, 0, 'h00, 0, 0};
        run_job(jx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr2dbuf_gen.md
DDR2DBUF_GEN -- requirements
Module: ddr2dbuf_gen

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, element width; BATCH, default 8, elements per beat; BUF_DEPTH, default 256, words per bank; ADDR_W, default bw(BUF_DEPTH), bank address width; CNT_W, default 4, conv counter width; BANK_NUM, fixed 4, banks arranged as a 2x2 row/pixel tile.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 start  in  1  one-cycle job request; sampled in IDLE only.
REQ-005 mode  in  2  2'b00 conv, 2'b01 fc, 2'b1x reserved.
REQ-006 ch_num / row_num / pix_num  in  CNT_W each  conv channel/row/pixel count minus one.
REQ-007 fc_len  in  ADDR_W  fc words per bank minus one.
REQ-008 base_addr  in  ADDR_W  start address in every bank.
REQ-009 abort  in  1  synchronous job cancel.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 ddr_data  in  DATA_W*BATCH  beat payload; ddr_valid  in  1; ddr_ready  out  1; a beat transfers when valid && ready.
REQ-013 dbuf_wr_addr  out  ADDR_W; dbuf_wr_data  out  [4][DATA_W*BATCH]; dbuf_wr_en  out  4, one-hot or zero.

Function
REQ-014 FSM states SHALL be IDLE, RUN, LAST; IDLE->RUN on start with mode[1]==0; RUN->LAST on acceptance of final beat; LAST->IDLE unconditionally after one cycle.
REQ-015 start in IDLE SHALL latch mode, ch_num, row_num, pix_num, fc_len, base_addr and clear all counters; config inputs SHALL be ignored at all other times.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 ddr_ready SHALL equal (state == RUN); beats offered outside RUN are not consumed.
REQ-018 Conv order SHALL be channel innermost, then pixel, then row; each accepted beat increments ch_cnt, wrapping at ch_num and then carrying into pix_cnt; pix_cnt wraps at pix_num and carries into row_cnt.
REQ-019 Conv final beat SHALL be ch_cnt==ch_num && pix_cnt==pix_num && row_cnt==row_num.
REQ-020 Conv write SHALL use bank {row_cnt[0], pix_cnt[0]}; address SHALL be base_addr + {ch_cnt, row_cnt[CNT_W-1:1], pix_cnt[CNT_W-1:1]}, truncated to ADDR_W, wrapping modulo 2^ADDR_W.
REQ-021 FC beat k SHALL write bank k mod 4 at address base_addr + (k div 4), modulo 2^ADDR_W; final beat is k == 4*fc_len+3.
REQ-022 Each accepted beat SHALL produce exactly one write, registered, with ddr_data on the addressed bank lane, one cycle after acceptance; other lanes hold their previous data, and their enables are 0.
REQ-023 done SHALL pulse in the LAST cycle, coincident with the final write.
REQ-024 start with mode[1]==1 SHALL go IDLE->LAST, producing no writes, with done pulsing on the next cycle.
REQ-025 abort in RUN SHALL return to IDLE next cycle with no done pulse; a write for a beat accepted in the abort cycle SHALL still issue; abort in IDLE or LAST SHALL be ignored.
REQ-026 ddr_valid gaps SHALL stall counters without affecting addressing.

Reset
REQ-027 While rst==0: state IDLE, all counters and latched config 0, busy/done/ddr_ready/dbuf_wr_en 0, dbuf_wr_addr 0, dbuf_wr_data 0.
REQ-028 Reset mid-job SHALL discard the job; no write or done SHALL issue after release until a new start.

Verification
REQ-029 Conv, ch_num=1, row_num=1, pix_num=1, base_addr=0x10, continuous valid -> 8 writes: addr 0x10 en 0001, addr 0x20 en 0001, 0x10/0010, 0x20/0010, 0x10/0100, 0x20/0100, 0x10/1000, 0x20/1000; done on the 8th.
REQ-030 FC, fc_len=1, base_addr=0xFF, ADDR_W=8 -> banks 0,1,2,3 at 0xFF, then banks 0..3 at 0x00 (wrap); done once; busy for 9 cycles.
REQ-031 Conv job with random ddr_valid gaps -> write sequence identical to the gap-free run; ddr_ready low in LAST.
REQ-032 abort after 3 accepted beats -> exactly 3 writes, no done, IDLE next cycle; new start then runs normally.
REQ-033 rst low for 1 cycle mid-job -> all outputs 0 immediately; no further writes; mode=2'b10 start -> done only, zero writes.
